// File: rtl/dcache_mem_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_mem_ctrl
//
// Purpose:
//   Fixed-latency backing memory for a data cache. Stores 2**DEPTH_LOG2 lines
//   of 256 bits. A request is accepted only in IDLE, and its address, write
//   flag and data are latched at that point. After LATENCY cycles a one-cycle
//   ack is returned. Writes commit on the edge entering ACK. Reads present the
//   line on mem_data_o from the ACK cycle until the next completed read.
//   Dropping mem_enable_i while BUSY cancels the request without side effects.
//   The DONE state swallows the cache's enable tail after an ack. If enable is
//   still high in the following IDLE cycle, a new request starts there.
//
// Parameters:
//   LATENCY     cycles from the accepting cycle to the ack cycle (2..255)
//   DEPTH_LOG2  log2 of the number of stored lines
//
// Ports:
//   clk_i         clock, all state changes on the rising edge
//   rst_i         synchronous active-high reset (array contents are kept)
//   mem_enable_i  request valid / hold; low while BUSY cancels the request
//   mem_write_i   1 = line write, 0 = line read
//   mem_addr_i    byte address; line index is bits [DEPTH_LOG2+4:5]
//   mem_data_i    write line data
//   mem_data_o    read line data (registered, held until the next read)
//   mem_ack_o     one-cycle completion pulse (registered)
//   rd_cnt_o      completed-read count
//   wr_cnt_o      completed-write count
//
// Build option:
//   DCACHE_MEM_CTRL_STATS_EN  when defined, rd_cnt_o/wr_cnt_o count completed
//                             reads/writes. Otherwise both outputs are tied to 0
//                             and no counter flops exist.
// -----------------------------------------------------------------------------
module dcache_mem_ctrl #(
  parameter int unsigned LATENCY    = 10,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mem_enable_i,
  input  logic         mem_write_i,
  input  logic [31:0]  mem_addr_i,
  input  logic [255:0] mem_data_i,
  output logic [255:0] mem_data_o,
  output logic         mem_ack_o,
  output logic [31:0]  rd_cnt_o,
  output logic [31:0]  wr_cnt_o
);

  localparam int unsigned LINES    = 1 << DEPTH_LOG2;
  localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  wr_q;
  logic [255:0]          wdata_q;
  logic [255:0]          rdata_q;
  logic                  ack_q;
  logic                  accept_s;
  logic                  complete_s;
  logic [255:0]          mem_q [LINES];

  // Offset bits and bits above the index do not select a line, so addresses alias.
  logic unused_addr_s;
  assign unused_addr_s = ^{mem_addr_i[31:DEPTH_LOG2+5], mem_addr_i[4:0]};

  // Next-state and counter logic for the request FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept_s   = 1'b0;
    complete_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_enable_i) begin
          accept_s = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = ST_BUSY;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Cancellation takes priority, even on the cycle that would complete.
        if (!mem_enable_i) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd1) begin
          state_d    = ST_ACK;
          cnt_d      = 8'd0;
          complete_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // Enable is ignored here: it is the cache's tail from the ack cycle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State, request latch, ack and read-data registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= 256'd0;
      rdata_q <= 256'd0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= complete_s;
      if (accept_s) begin
        idx_q   <= mem_addr_i[DEPTH_LOG2+4:5];
        wr_q    <= mem_write_i;
        wdata_q <= mem_data_i;
      end
      if (complete_s && !wr_q) begin
        rdata_q <= mem_q[idx_q];
      end
    end
  end

  // Line storage; not reset, and a reset edge blocks an in-flight commit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && complete_s && wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign mem_data_o = rdata_q;
  assign mem_ack_o  = ack_q;

`ifdef DCACHE_MEM_CTRL_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  // Completed-transfer statistics; cancelled requests never reach complete_s.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else if (complete_s) begin
      if (wr_q) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end else begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`else
  assign rd_cnt_o = 32'd0;
  assign wr_cnt_o = 32'd0;
`endif

endmodule
